// File: rtl/banked_scatter_crossbar.sv
// rtl/banked_scatter_crossbar.sv - scatters masked product lanes into output banks, draining bank conflicts over cycles.
// Optional macro XBAR_CONFLICT_STATS_EN enables the saturating conflict_cycles counter.
module banked_scatter_crossbar #(
    parameter int LANES      = 16,
    parameter int BANK_COUNT = 32,
    parameter int TILE_SIZE  = 256,
    parameter int PROD_WIDTH = 16,
    localparam int CW        = $clog2(TILE_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [1:0]                            mode,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [LANES-1:0]                      in_mask,
    input  logic [LANES-1:0][CW-1:0]              in_row,
    input  logic [LANES-1:0][CW-1:0]              in_col,
    input  logic [LANES-1:0][PROD_WIDTH-1:0]      in_data,
    output logic [BANK_COUNT-1:0]                 bank_we,
    output logic [BANK_COUNT-1:0][CW-1:0]         bank_entry,
    output logic [BANK_COUNT-1:0][CW-1:0]         bank_col,
    output logic [BANK_COUNT-1:0][7:0]            bank_data,
    output logic                                  busy,
    output logic [15:0]                           conflict_cycles
);
    localparam int BW = $clog2(BANK_COUNT);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                              state_q, state_d;
    logic [1:0]                          m_q, m_d;
    logic [LANES-1:0]                    pend_q, pend_d;
    logic [LANES-1:0][CW-1:0]            row_q, row_d, col_q, col_d;
    logic [LANES-1:0][PROD_WIDTH-1:0]    data_q, data_d;
    logic [BANK_COUNT-1:0]               we_q, we_d;
    logic [BANK_COUNT-1:0][CW-1:0]       entry_q, entry_d, bcol_q, bcol_d;
    logic [BANK_COUNT-1:0][7:0]          bdata_q, bdata_d;
    logic [BANK_COUNT-1:0]               taken;
    logic [BW-1:0]                       lb;

    // Row low bits spread across bank groups so narrow precisions interleave rows.
    function automatic logic [BW-1:0] bank_of(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                              input logic [1:0] m);
        int unsigned ri, ci, t;
        ri = 32'(r);
        ci = 32'(c);
        t  = ci + (ri >> m) * 3 + (ri & ((32'd1 << m) - 32'd1)) * 32'(BANK_COUNT >> m);
        return t[BW-1:0];
    endfunction

    function automatic logic [7:0] pack_data(input logic [PROD_WIDTH-1:0] d, input logic [1:0] m);
        case (m)
            2'd0:    return {6'd0, d[PROD_WIDTH-1], d[0]};
            2'd1:    return {4'd0, d[PROD_WIDTH-1], d[2:0]};
            default: return {d[PROD_WIDTH-1], d[6:0]};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        pend_d  = pend_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        we_d    = '0;
        entry_d = entry_q;
        bcol_d  = bcol_q;
        bdata_d = bdata_q;
        taken   = '0;
        lb      = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = (mode == 2'd3) ? 2'd0 : mode;
                    pend_d  = in_mask;
                    row_d   = in_row;
                    col_d   = in_col;
                    data_d  = in_data;
                    state_d = DRAIN;
                end
            end
            default: begin
                // Ascending lane scan: first pending lane to reach a bank wins it this cycle.
                for (int l = 0; l < LANES; l++) begin
                    if (pend_q[l]) begin
                        lb = bank_of(row_q[l], col_q[l], m_q);
                        if (!taken[lb]) begin
                            taken[lb]   = 1'b1;
                            pend_d[l]   = 1'b0;
                            we_d[lb]    = 1'b1;
                            entry_d[lb] = row_q[l] >> m_q;
                            bcol_d[lb]  = col_q[l];
                            bdata_d[lb] = pack_data(data_q[l], m_q);
                        end
                    end
                end
                if (pend_d == '0) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            pend_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            we_q    <= '0;
            entry_q <= '0;
            bcol_q  <= '0;
            bdata_q <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            pend_q  <= pend_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            we_q    <= we_d;
            entry_q <= entry_d;
            bcol_q  <= bcol_d;
            bdata_q <= bdata_d;
        end
    end

`ifdef XBAR_CONFLICT_STATS_EN
    logic [15:0] conf_q, conf_d;

    always_comb begin
        conf_d = conf_q;
        if (state_q == DRAIN && pend_d != '0 && conf_q != 16'hFFFF) begin
            conf_d = conf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conf_q <= '0;
        end else begin
            conf_q <= conf_d;
        end
    end

    assign conflict_cycles = conf_q;
`else
    assign conflict_cycles = 16'd0;
`endif

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == DRAIN);
    assign bank_we    = we_q;
    assign bank_entry = entry_q;
    assign bank_col   = bcol_q;
    assign bank_data  = bdata_q;

endmodule
